// File: rtl/score_keeper.sv
// Two-player BCD scorekeeper with seven-segment drive, match-end detection and winner blink.
// Goal edge -> score/digits next cycle -> segments the cycle after; new_match overrides goal events.
module score_keeper #(
  parameter int WIN_SCORE    = 11,
  parameter int BLINK_CYCLES = 12_587_500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       new_match,
  input  logic       pause,
  output logic [6:0] score_left,
  output logic [6:0] score_right,
  output logic [6:0] hex_left_tens,
  output logic [6:0] hex_left_ones,
  output logic [6:0] hex_right_tens,
  output logic [6:0] hex_right_ones,
  output logic       match_over,
  output logic [1:0] winner
);

  typedef enum logic {PLAY, WON} state_t;

  localparam int             CW        = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_MAX   = CW'(BLINK_CYCLES - 1);
  localparam logic [6:0]     WIN       = 7'(WIN_SCORE);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;
  localparam logic [6:0]     SEG_ZERO  = 7'b1000000;

  state_t        state, state_nxt;
  logic          prev_goal_left, prev_goal_right;
  logic [7:0]    left_bcd, right_bcd, left_nxt, right_nxt;
  logic [1:0]    winner_nxt;
  logic [CW-1:0] blink_cnt, cnt_nxt;
  logic          blink_on, on_nxt;
  logic          evt_left, evt_right, left_win, right_win;
  logic          blank_left, blank_right;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else                bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [6:0] bcd_bin(input logic [7:0] v);
    bcd_bin = {3'b000, v[7:4]} * 7'd10 + {3'b000, v[3:0]};
  endfunction

  assign evt_left   = goal_left & ~prev_goal_left;
  assign evt_right  = goal_right & ~prev_goal_right;
  assign match_over = (state == WON);

  always_comb begin
    state_nxt  = state;
    left_nxt   = left_bcd;
    right_nxt  = right_bcd;
    winner_nxt = winner;
    cnt_nxt    = blink_cnt;
    on_nxt     = blink_on;
    left_win   = 1'b0;
    right_win  = 1'b0;
    if (new_match) begin
      state_nxt  = PLAY;
      left_nxt   = 8'h00;
      right_nxt  = 8'h00;
      winner_nxt = 2'b00;
      cnt_nxt    = '0;
      on_nxt     = 1'b1;
    end else begin
      case (state)
        PLAY: begin
          if (evt_left && !pause)  left_nxt  = bcd_inc(left_bcd);
          if (evt_right && !pause) right_nxt = bcd_inc(right_bcd);
          left_win  = evt_left && !pause && (bcd_bin(left_nxt) == WIN);
          right_win = evt_right && !pause && (bcd_bin(right_nxt) == WIN);
          if (left_win || right_win) begin
            state_nxt  = WON;
            winner_nxt = {right_win, left_win};
          end
        end
        WON: begin
          if (blink_cnt == CNT_MAX) begin
            cnt_nxt = '0;
            on_nxt  = ~blink_on;
          end else begin
            cnt_nxt = blink_cnt + 1'b1;
          end
        end
        default: state_nxt = PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= PLAY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_goal_left  <= 1'b0;
      prev_goal_right <= 1'b0;
      left_bcd        <= 8'h00;
      right_bcd       <= 8'h00;
      score_left      <= 7'd0;
      score_right     <= 7'd0;
      winner          <= 2'b00;
      blink_cnt       <= '0;
      blink_on        <= 1'b1;
    end else begin
      prev_goal_left  <= goal_left;
      prev_goal_right <= goal_right;
      left_bcd        <= left_nxt;
      right_bcd       <= right_nxt;
      score_left      <= bcd_bin(left_nxt);
      score_right     <= bcd_bin(right_nxt);
      winner          <= winner_nxt;
      blink_cnt       <= cnt_nxt;
      blink_on        <= on_nxt;
    end
  end

  // Winner's digits go dark during the off phase; a draw blanks both sides.
  assign blank_left  = (state == WON) && !blink_on && winner[0];
  assign blank_right = (state == WON) && !blink_on && winner[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_left_tens  <= SEG_BLANK;
      hex_left_ones  <= SEG_ZERO;
      hex_right_tens <= SEG_BLANK;
      hex_right_ones <= SEG_ZERO;
    end else begin
      hex_left_tens  <= (blank_left || left_bcd[7:4] == 4'd0) ? SEG_BLANK : seg(left_bcd[7:4]);
      hex_left_ones  <= blank_left ? SEG_BLANK : seg(left_bcd[3:0]);
      hex_right_tens <= (blank_right || right_bcd[7:4] == 4'd0) ? SEG_BLANK : seg(right_bcd[7:4]);
      hex_right_ones <= blank_right ? SEG_BLANK : seg(right_bcd[3:0]);
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench: default-parameter instance for counting/display, WIN_SCORE=3 instance for match end.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst, goal_left, goal_right, new_match, pause;

  logic [6:0] a_sl, a_sr, a_hlt, a_hlo, a_hrt, a_hro;
  logic       a_mo;
  logic [1:0] a_win;
  logic [6:0] b_sl, b_sr, b_hlt, b_hlo, b_hrt, b_hro;
  logic       b_mo;
  logic [1:0] b_win;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S0    = 7'b1000000;
  localparam logic [6:0] S1    = 7'b1111001;
  localparam logic [6:0] S2    = 7'b0100100;
  localparam logic [6:0] S3    = 7'b0110000;

  always #5 clk = ~clk;

  score_keeper dut_a (
    .clk(clk), .rst(rst), .goal_left(goal_left), .goal_right(goal_right),
    .new_match(new_match), .pause(pause),
    .score_left(a_sl), .score_right(a_sr),
    .hex_left_tens(a_hlt), .hex_left_ones(a_hlo),
    .hex_right_tens(a_hrt), .hex_right_ones(a_hro),
    .match_over(a_mo), .winner(a_win)
  );

  score_keeper #(.WIN_SCORE(3), .BLINK_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .goal_left(goal_left), .goal_right(goal_right),
    .new_match(new_match), .pause(pause),
    .score_left(b_sl), .score_right(b_sr),
    .hex_left_tens(b_hlt), .hex_left_ones(b_hlo),
    .hex_right_tens(b_hrt), .hex_right_ones(b_hro),
    .match_over(b_mo), .winner(b_win)
  );

  typedef struct {
    logic gl;
    logic gr;
    logic p;
    int   sl;
    int   sr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic gl, input logic gr, input logic p, input int sl, input int sr);
    vec_t v;
    v.gl = gl; v.gr = gr; v.p = p; v.sl = sl; v.sr = sr;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; goal_left = 1'b0; goal_right = 1'b0; new_match = 1'b0; pause = 1'b0;
    #12;
    chk("rst_score_left", a_sl, 0);
    chk("rst_score_right", a_sr, 0);
    chk("rst_hex_lt", a_hlt, BLANK);
    chk("rst_hex_lo", a_hlo, S0);
    chk("rst_hex_rt", a_hrt, BLANK);
    chk("rst_hex_ro", a_hro, S0);
    chk("rst_match_over", a_mo, 0);
    chk("rst_winner", a_win, 0);
    rst = 1'b0;

    // First goal: score after one clock, segments after two
    goal_left = 1'b1;
    step();
    chk("t1_score_left", a_sl, 1);
    chk("t1_hex_lo_lag", a_hlo, S0);
    step();
    chk("t1_hex_lo", a_hlo, S1);
    chk("t1_hex_lt", a_hlt, BLANK);
    chk("t1_hex_ro", a_hro, S0);
    chk("t1_hex_rt", a_hrt, BLANK);

    // Held level, paused edges, then counting up to left=9, right=2
    for (int i = 0; i < 9; i++) add(1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0); add(0, 0, 1, 1, 0); add(1, 0, 1, 1, 0);
    add(0, 0, 1, 1, 0); add(1, 0, 1, 1, 0); add(0, 0, 1, 1, 0);
    add(0, 0, 0, 1, 0);
    add(1, 0, 0, 2, 0); add(0, 1, 0, 2, 1); add(1, 0, 0, 3, 1);
    add(0, 0, 0, 3, 1); add(1, 1, 0, 4, 2);
    for (int s = 5; s <= 9; s++) begin
      add(0, 0, 0, s - 1, 2);
      add(1, 0, 0, s, 2);
    end
    add(0, 0, 0, 9, 2);
    for (int i = 0; i < vecs.size(); i++) begin
      goal_left = vecs[i].gl; goal_right = vecs[i].gr; pause = vecs[i].p;
      step();
      chk($sformatf("vec%0d_score_left", i), a_sl, vecs[i].sl);
      chk($sformatf("vec%0d_score_right", i), a_sr, vecs[i].sr);
    end
    pause = 1'b0; goal_right = 1'b0;

    // 9 -> 10 carries into the tens digit
    goal_left = 1'b1;
    step();
    chk("t3_score_left", a_sl, 10);
    step();
    chk("t3_hex_lt", a_hlt, S1);
    chk("t3_hex_lo", a_hlo, S0);
    chk("t3_hex_ro", a_hro, S2);
    goal_left = 1'b0;
    step();

    // Left wins at 3 on the small instance; blink with half-period 4
    rst = 1'b1; #2; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      goal_left = 1'b1; step();
      goal_left = 1'b0; if (i < 2) step();
    end
    chk("t4_score_left", b_sl, 3);
    chk("t4_match_over", b_mo, 1);
    chk("t4_winner", b_win, 1);
    for (int k = 1; k <= 12; k++) begin
      goal_left  = (k == 2);
      goal_right = (k == 6);
      step();
      chk($sformatf("t4_k%0d_hex_lo", k), b_hlo, (((k - 1) / 4) % 2) ? BLANK : S3);
      chk($sformatf("t4_k%0d_hex_ro", k), b_hro, S0);
      chk($sformatf("t4_k%0d_hex_rt", k), b_hrt, BLANK);
    end
    goal_left = 1'b0; goal_right = 1'b0;
    chk("t4_held_left", b_sl, 3);
    chk("t4_held_right", b_sr, 0);
    chk("t4_still_won", b_mo, 1);

    // new_match wins over a coincident goal edge; held level does not score later
    new_match = 1'b1; goal_right = 1'b1;
    step();
    chk("t6_nm_score_left", b_sl, 0);
    chk("t6_nm_score_right", b_sr, 0);
    chk("t6_nm_match_over", b_mo, 0);
    chk("t6_nm_winner", b_win, 0);
    new_match = 1'b0;
    step();
    chk("t6_held_right", b_sr, 0);
    goal_right = 1'b0;
    step();

    // Draw: both reach 3 together
    for (int i = 0; i < 3; i++) begin
      goal_left = 1'b1; goal_right = 1'b1; step();
      goal_left = 1'b0; goal_right = 1'b0; if (i < 2) step();
    end
    chk("t5_score_left", b_sl, 3);
    chk("t5_score_right", b_sr, 3);
    chk("t5_winner", b_win, 3);
    chk("t5_match_over", b_mo, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("t5_k%0d_hex_lo", k), b_hlo, (((k - 1) / 4) % 2) ? BLANK : S3);
      chk($sformatf("t5_k%0d_hex_ro", k), b_hro, (((k - 1) / 4) % 2) ? BLANK : S3);
    end

    // Asynchronous reset mid-blink, no clock edge in between
    rst = 1'b1;
    #1;
    chk("t6_rst_hex_lo", b_hlo, S0);
    chk("t6_rst_hex_lt", b_hlt, BLANK);
    chk("t6_rst_hex_ro", b_hro, S0);
    chk("t6_rst_score_left", b_sl, 0);
    chk("t6_rst_match_over", b_mo, 0);
    chk("t6_rst_winner", b_win, 0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
